// File: rtl/fetch_decode_unit_if.sv
// Bus between the fetch/decode stage, the instruction memory and the control unit.
// The master side drives the request/handshake inputs and memory data.
// The slave side is the fetch/decode stage itself.
interface fetch_decode_unit_if;
  logic        fetch_start;
  logic [31:0] pc_in;
  logic [31:0] mem_data;
  logic        dec_ready;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic        busy;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] jump_target;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        illegal_op;

  modport master (
    output fetch_start, pc_in, mem_data, dec_ready,
    input  mem_addr, mem_wr, busy, instr_valid, instr, opcode, funct,
           rs, rt, rd, shamt, imm_sext, jump_target, pc_plus4,
           misaligned, illegal_op
  );

  modport slave (
    input  fetch_start, pc_in, mem_data, dec_ready,
    output mem_addr, mem_wr, busy, instr_valid, instr, opcode, funct,
           rs, rt, rd, shamt, imm_sext, jump_target, pc_plus4,
           misaligned, illegal_op
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Multicycle MIPS fetch/decode stage: presents a fetch address, waits a fixed
// memory latency, captures the instruction word and holds the decoded fields
// for the control unit until it is accepted.
module fetch_decode_unit #(
  parameter int MEM_LATENCY = 1  // 1..15 cycles from address to valid data
) (
  input  logic               clock,
  input  logic               reset,
  fetch_decode_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, CAPTURE, HOLD} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_d;
  logic [31:0] mem_addr_q;
  logic [31:0] instr_q;
  logic [3:0]  cnt_q;
  logic        mis_q;
  logic        start;
  logic        unaligned;
  logic        op_ok;
  logic        fn_ok;

  // A new fetch is taken from IDLE, or from HOLD in the same cycle the
  // current instruction is accepted (back-to-back, no idle bubble).
  assign start     = bus.fetch_start &
                     ((state == IDLE) | ((state == HOLD) & bus.dec_ready));
  assign unaligned = (bus.pc_in[1:0] != 2'b00);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; a misaligned fetch skips the memory wait entirely.
  always_comb begin
    // NOTE: the default comes first so every path assigns state_d and no
    // latch is inferred.
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = unaligned ? HOLD : REQ;
      REQ:     if (cnt_q == 4'd0) state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD: begin
        if (start)              state_d = unaligned ? HOLD : REQ;
        else if (bus.dec_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch address, wait counter, instruction register and misaligned flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_q <= '0;
      instr_q    <= '0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
    end else begin
      if (start) begin
        mem_addr_q <= bus.pc_in;
        mis_q      <= unaligned;
        cnt_q      <= WAIT_INIT;
        if (unaligned) instr_q <= '0;
      end else if ((state == REQ) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state == CAPTURE) begin
        instr_q <= bus.mem_data;
        mis_q   <= 1'b0;
      end
    end
  end

  // Supported primary opcodes.
  always_comb begin
    op_ok = 1'b0;
    case (instr_q[31:26])
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0F,
      6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  // Supported R-type function codes (only meaningful when opcode is 0).
  always_comb begin
    fn_ok = 1'b0;
    case (instr_q[5:0])
      6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0D, 6'h10, 6'h12,
      6'h13, 6'h18, 6'h1A, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h26,
      6'h2A: fn_ok = 1'b1;
      default: fn_ok = 1'b0;
    endcase
  end

  // Decoded fields are driven from the registers at all times; they are
  // only meaningful while instr_valid is high.
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr      = 1'b0;
  assign bus.busy        = (state == REQ) | (state == CAPTURE);
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.rs          = instr_q[25:21];
  assign bus.rt          = instr_q[20:16];
  assign bus.rd          = instr_q[15:11];
  assign bus.shamt       = instr_q[10:6];
  assign bus.funct       = instr_q[5:0];
  assign bus.imm_sext    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign bus.pc_plus4    = mem_addr_q + 32'd4;
  assign bus.jump_target = {bus.pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign bus.misaligned  = mis_q;
  assign bus.illegal_op  = bus.instr_valid & ~mis_q &
                           ~(op_ok & ((instr_q[31:26] != 6'h00) | fn_ok));

endmodule
